// File: rtl/store_memory_encoder.sv
// Store encoder: turns SB/SH/SW requests into word-aligned memory writes with byte strobes, buffered in a FIFO.
// Optional macro STORE_ENCODER_STATS_EN adds issued/rejected 32-bit counters.
module store_memory_encoder #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              idle
`ifdef STORE_ENCODER_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_rejected
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } wr_t;

  wr_t              fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       off;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic             reject;
  wr_t              enc;

  // Lane encoding and legality of the incoming store
  always_comb begin
    off       = req_addr[1:0];
    enc.addr  = {req_addr[ADDR_W-1:2], 2'b00};
    enc.wdata = req_data;
    enc.wstrb = 4'b1111;
    legal     = 1'b0;
    case (req_type)
      3'b000: begin
        enc.wdata = {4{req_data[7:0]}};
        enc.wstrb = 4'b0001 << off;
        legal     = 1'b1;
      end
      3'b001: begin
        enc.wdata = {2{req_data[15:0]}};
        enc.wstrb = 4'b0011 << off;
        legal     = ~off[0];
      end
      3'b010: legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
    accept    = req_valid && req_ready;
    push      = accept && legal;
    reject    = accept && !legal;
    pop       = mem_valid && mem_ready;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Buffer state; handshake flags are registered from the next count so mem_ready never reaches req_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      idle      <= 1'b1;
      err_valid <= 1'b0;
      err_addr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= enc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (reject) err_addr <= req_addr;
      count     <= count_nxt;
      req_ready <= (count_nxt != FULL);
      mem_valid <= (count_nxt != '0);
      err_valid <= reject;
      idle      <= (count_nxt == '0) && !reject;
    end
  end

  assign mem_addr  = fifo_q[rd_ptr].addr;
  assign mem_wdata = fifo_q[rd_ptr].wdata;
  assign mem_wstrb = fifo_q[rd_ptr].wstrb;

`ifdef STORE_ENCODER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued   <= '0;
      stat_rejected <= '0;
    end else begin
      if (pop)    stat_issued   <= stat_issued + 32'd1;
      if (reject) stat_rejected <= stat_rejected + 32'd1;
    end
  end
`endif

endmodule
